// File: rtl/isp_uart_host_if.sv
// Command/response handshake between a requester and isp_uart_host.
interface isp_uart_host_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_op;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;

  modport master (output i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data,
                  input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err);
  modport slave  (input  i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data,
                  output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err);
endinterface

// File: rtl/isp_uart_host.sv
// Host side of the UART ISP debug port: serializes one ASCII command line,
// then collects and checks the 8-character reply.
module isp_uart_host #(
  parameter int UART_CLK_DIV   = 434,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic           clk,
  input  logic           rst,
  isp_uart_host_if.slave bus,
  output logic           o_uart_tx,
  input  logic           i_uart_rx
);
  localparam int CW = $clog2(UART_CLK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(UART_CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(UART_CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_RESET = 3'd2;
  localparam logic [2:0] OP_RUN   = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Nibble k of w, counting from the most significant nibble.
  function automatic logic [3:0] nib(input logic [31:0] w, input logic [2:0] k);
    logic [31:0] s;
    s = w << {k, 2'b00};
    return s[31:28];
  endfunction

  // Byte i of the command line for the given op.
  function automatic logic [7:0] tx_byte(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] d, input logic [4:0] i);
    logic [7:0] b;
    b = 8'h0a;
    case (op)
      OP_READ:  if (i < 5'd8) b = hex_char(nib(a, i[2:0]));
      OP_WRITE: if (i < 5'd8) b = hex_char(nib(a, i[2:0]));
                else if (i == 5'd8) b = 8'h20;
                else if (i < 5'd17) b = hex_char(nib(d, 3'(i - 5'd9)));
      OP_RESET: if (i == 5'd0) b = 8'h72;
                else if (i < 5'd9) b = hex_char(nib(a, 3'(i - 5'd1)));
      OP_RUN:   if (i == 5'd0) b = 8'h77;
      OP_STOP:  if (i == 5'd0) b = 8'h73;
      default:  b = 8'h0a;
    endcase
    return b;
  endfunction

  // Index of the final byte ('\n') of each command line.
  function automatic logic [4:0] tx_last(input logic [2:0] op);
    case (op)
      OP_READ:  return 5'd8;
      OP_WRITE: return 5'd17;
      OP_RESET: return 5'd9;
      default:  return 5'd1;
    endcase
  endfunction

  // Expected character k of the fixed reply for non-read ops.
  function automatic logic [7:0] exp_char(input logic [2:0] op, input logic [2:0] k);
    logic [63:0] s;
    case (op)
      OP_WRITE: s = "wr done ";
      OP_RESET: s = "rst done";
      OP_RUN:   s = "running ";
      default:  s = "stoped  ";
    endcase
    s = s << {k, 3'b000};
    return s[63:56];
  endfunction

  // {valid, value} of a lowercase hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q, data_q;
  logic [4:0]  byte_idx_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]  tx_bit_q;
  logic        tx_q;
  logic [2:0]  kept_cnt_q;
  logic [27:0] acc_q;
  logic        mism_q;
  logic [TW-1:0] to_cnt_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  rx_state_t   rx_st_q, rx_st_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  logic       accept, op_legal, frame_end, last_byte, to_fire, wait_end;
  logic       rx_fall, rx_last, rx_done, rx_ferr, byte_skip, kept, byte_bad, reply_done;
  logic [7:0] cur_byte;
  logic [4:0] hexv;

  assign accept    = (state_q == S_IDLE) && bus.i_cmd_valid;
  assign op_legal  = (bus.i_cmd_op <= OP_STOP);
  assign cur_byte  = tx_byte(op_q, addr_q, data_q, byte_idx_q);
  assign frame_end = (state_q == S_SEND) && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);
  assign last_byte = (byte_idx_q == tx_last(op_q));

  assign rx_fall   = rx_prev_q & ~rx_s2_q;
  assign rx_last   = (rx_st_q == R_START) ? (rx_cnt_q == HALF_LAST) : (rx_cnt_q == BIT_LAST);
  assign rx_done   = (rx_st_q == R_STOP) && rx_last;
  assign rx_ferr   = ~rx_s2_q;
  assign byte_skip = (rx_sh_q == 8'h0d) || (rx_sh_q == 8'h0a) || (rx_sh_q == 8'h00);
  assign kept      = (state_q == S_WAIT) && rx_done && !rx_ferr && !byte_skip;
  assign hexv      = hex_val(rx_sh_q);
  assign byte_bad  = (op_q == OP_READ) ? !hexv[4] : (rx_sh_q != exp_char(op_q, kept_cnt_q));
  assign reply_done = kept && (kept_cnt_q == 3'd7);
  assign to_fire   = (state_q == S_WAIT) && (to_cnt_q == TO_LAST);
  assign wait_end  = (state_q == S_WAIT) && ((rx_done && rx_ferr) || reply_done || to_fire);

  assign o_uart_tx       = tx_q;
  assign bus.o_cmd_ready = (state_q == S_IDLE);
  assign bus.o_rsp_valid = (state_q == S_RESP);
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;

  // Receiver frame sequencing: start check at half bit, 8 data bits, stop bit.
  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      R_IDLE:  if (rx_fall) rx_st_d = R_START;
      R_START: if (rx_last) rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
      R_DATA:  if (rx_last && rx_bit_q == 3'd7) rx_st_d = R_STOP;
      R_STOP:  if (rx_last) rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
  end

  // Receiver synchronizer, bit timer and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q   <= R_IDLE;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_st_q   <= rx_st_d;
      rx_s1_q   <= i_uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rx_st_q == R_IDLE || rx_last) rx_cnt_q <= '0;
      else rx_cnt_q <= rx_cnt_q + CW'(1);
      if (rx_st_q == R_START) rx_bit_q <= '0;
      if (rx_st_q == R_DATA && rx_last) begin
        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_q <= rx_bit_q + 3'd1;
      end
    end
  end

  // Command FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_cmd_valid) state_d = op_legal ? S_SEND : S_RESP;
      S_SEND:  if (frame_end && last_byte) state_d = S_WAIT;
      S_WAIT:  if (wait_end) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command FSM state, transmitter, reply collection and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      kept_cnt_q <= '0;
      acc_q      <= '0;
      mism_q     <= 1'b0;
      to_cnt_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= bus.i_cmd_op;
        addr_q     <= bus.i_cmd_addr;
        data_q     <= bus.i_cmd_data;
        byte_idx_q <= '0;
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        kept_cnt_q <= '0;
        acc_q      <= '0;
        mism_q     <= 1'b0;
        if (op_legal) begin
          tx_q <= 1'b0;
        end else begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end else if (state_q == S_SEND) begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 4'd9) begin
            // Next start bit follows the stop bit with no gap.
            if (!last_byte) begin
              byte_idx_q <= byte_idx_q + 5'd1;
              tx_bit_q   <= '0;
              tx_q       <= 1'b0;
            end
            to_cnt_q <= '0;
          end else begin
            tx_bit_q <= tx_bit_q + 4'd1;
            tx_q     <= (tx_bit_q == 4'd8) ? 1'b1 : cur_byte[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + CW'(1);
        end
      end else if (state_q == S_WAIT) begin
        if (rx_st_q == R_IDLE && rx_fall) to_cnt_q <= '0;
        else to_cnt_q <= to_cnt_q + TW'(1);
        if (kept) begin
          kept_cnt_q <= kept_cnt_q + 3'd1;
          acc_q      <= {acc_q[23:0], hexv[3:0]};
          if (byte_bad) mism_q <= 1'b1;
        end
        if (wait_end) begin
          if (reply_done && !mism_q && !byte_bad) begin
            rsp_err_q  <= 1'b0;
            rsp_data_q <= (op_q == OP_READ) ? {acc_q, hexv[3:0]} : 32'd0;
          end else begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_isp_uart_host.sv
`timescale 1ns/1ps
module tb_isp_uart_host;
  localparam int DIV = 16;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic rx = 1'b1;

  isp_uart_host_if bus();

  isp_uart_host #(.UART_CLK_DIV(DIV), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_uart_tx(tx), .i_uart_rx(rx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int rsp_cyc = 0;
  int long_pulses = 0;
  int rsp_snap = 0;
  int last_start = 0;
  logic [31:0] rsp_data = '0;
  logic rsp_err = 1'b0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_rsp_valid === 1'b1) begin
      rsp_cnt  <= rsp_cnt + 1;
      rsp_cyc  <= cyc;
      rsp_data <= bus.o_rsp_data;
      rsp_err  <= bus.o_rsp_err;
      if (prev_v) long_pulses <= long_pulses + 1;
    end
    prev_v <= (bus.o_rsp_valid === 1'b1);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    checks++;
    if (bus.o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: ready=%b required=1", bus.o_cmd_ready);
    end
    rsp_snap = rsp_cnt;
    bus.i_cmd_op = op; bus.i_cmd_addr = a; bus.i_cmd_data = d; bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1 bus.i_cmd_valid = 1'b0;
  endtask

  // Every cycle of every frame is compared against the expected line level.
  task automatic check_tx(input string exp, input string name);
    int n, bad;
    logic [7:0] e, got;
    logic want;
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (tx !== 1'b0) begin
      errors++; $display("FAIL %s tx_start: line=%b required=0", name, tx);
      return;
    end
    for (int i = 0; i < exp.len(); i++) begin
      e = exp[i]; got = '0; bad = 0;
      last_start = cyc;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < DIV; c++) begin
          want = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
          if (tx !== want) bad++;
          if (c == DIV/2 && b >= 1 && b <= 8) got[b-1] = tx;
          @(negedge clk);
        end
      end
      checks++;
      if (got !== e || bad != 0) begin
        errors++; $display("FAIL %s tx_byte%0d: got=%h bad_cycles=%0d required=%h", name, i, got, bad, e);
      end
    end
  endtask

  task automatic send_rx(input string s, input logic stop_lvl);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      rx = 1'b0; repeat (DIV) @(negedge clk);
      for (int k = 0; k < 8; k++) begin rx = b[k]; repeat (DIV) @(negedge clk); end
      rx = stop_lvl; repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_rsp(input string name, input int max);
    int n;
    n = 0;
    while (rsp_cnt == rsp_snap && n < max) begin @(negedge clk); n++; end
    checks++;
    if (rsp_cnt == rsp_snap) begin
      errors++; $display("FAIL %s rsp_wait: no response within %0d cycles", name, max);
    end
  endtask

  task automatic check_rsp(input string name, input logic [31:0] d, input logic e);
    checks++;
    if (rsp_data !== d || rsp_err !== e) begin
      errors++; $display("FAIL %s rsp: data=%h err=%b required data=%h err=%b", name, rsp_data, rsp_err, d, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || bus.o_cmd_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0 ||
        bus.o_rsp_data !== 32'd0 || bus.o_rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_values: tx=%b ready=%b valid=%b data=%h err=%b required 1 1 0 0 0",
                         tx, bus.o_cmd_ready, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    issue(3'd0, 32'h0000_0100, 32'd0);
    check_tx("00000100\n", "read");
    send_rx("928cd0f1\n", 1'b1);
    wait_rsp("read", 200);
    check_rsp("read", 32'h928c_d0f1, 1'b0);
  endtask

  task automatic test_write();
    issue(3'd1, 32'h0000_0104, 32'hDEAD_BEEF);
    check_tx("00000104 deadbeef\n", "write");
    send_rx("wr done \n", 1'b1);
    wait_rsp("write", 200);
    check_rsp("write", 32'd0, 1'b0);
  endtask

  task automatic test_reset_run();
    issue(3'd2, 32'h0000_0200, 32'd0);
    check_tx("r00000200\n", "rst_cmd");
    send_rx("rst done", 1'b1);
    wait_rsp("rst_cmd", 200);
    check_rsp("rst_cmd", 32'd0, 1'b0);
    issue(3'd3, 32'd0, 32'd0);
    check_tx("w\n", "run");
    send_rx("\r\nrunning ", 1'b1);
    wait_rsp("run", 200);
    check_rsp("run", 32'd0, 1'b0);
  endtask

  // Stop, then a read issued on the first cycle ready is back.
  task automatic test_back_to_back();
    int n;
    issue(3'd4, 32'd0, 32'd0);
    check_tx("s\n", "stop");
    fork
      send_rx("stoped  ", 1'b1);
      begin
        n = 0;
        while (bus.o_rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b0 || bus.o_rsp_data !== 32'd0) begin
          errors++; $display("FAIL stop rsp: valid=%b err=%b data=%h required 1 0 0",
                             bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data);
        end
        @(negedge clk);
        checks++;
        if (bus.o_cmd_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
          errors++; $display("FAIL b2b ready: ready=%b valid=%b required 1 0", bus.o_cmd_ready, bus.o_rsp_valid);
        end
        rsp_snap = rsp_cnt;
        bus.i_cmd_op = 3'd0; bus.i_cmd_addr = 32'h0000_0010; bus.i_cmd_valid = 1'b1;
        @(posedge clk); #1 bus.i_cmd_valid = 1'b0;
        check_tx("00000010\n", "b2b_read");
      end
    join
    send_rx("0000abcd", 1'b1);
    wait_rsp("b2b_read", 200);
    check_rsp("b2b_read", 32'h0000_abcd, 1'b0);
  endtask

  task automatic test_errors();
    issue(3'd0, 32'h0000_0100, 32'd0);
    check_tx("00000100\n", "bad_hex");
    send_rx("92xcd0f1", 1'b1);
    wait_rsp("bad_hex", 200);
    check_rsp("bad_hex", 32'd0, 1'b1);

    issue(3'd0, 32'h0000_0300, 32'd0);
    check_tx("00000300\n", "timeout");
    wait_rsp("timeout", TMO + 100);
    check_rsp("timeout", 32'd0, 1'b1);
    checks++;
    if (rsp_cyc - last_start != 10*DIV + TMO) begin
      errors++; $display("FAIL timeout_latency: got=%0d required=%0d", rsp_cyc - last_start, 10*DIV + TMO);
    end

    issue(3'd0, 32'h0000_0100, 32'd0);
    check_tx("00000100\n", "framing");
    send_rx("9", 1'b0);
    wait_rsp("framing", 200);
    check_rsp("framing", 32'd0, 1'b1);
  endtask

  task automatic test_illegal_and_rst();
    int lows;
    @(negedge clk);
    bus.i_cmd_op = 3'd6; bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1 bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_err !== 1'b1 || bus.o_rsp_data !== 32'd0 || tx !== 1'b1) begin
      errors++; $display("FAIL illegal rsp: valid=%b err=%b data=%h tx=%b required 1 1 0 1",
                         bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data, tx);
    end
    lows = 0;
    repeat (50) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL illegal tx_quiet: low_cycles=%0d required=0", lows); end

    issue(3'd1, 32'h0000_0104, 32'h1234_5678);
    repeat (6) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL rst_pre tx: line=%b required=0", tx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || bus.o_cmd_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_frame: tx=%b ready=%b valid=%b required 1 1 0", tx, bus.o_cmd_ready, bus.o_rsp_valid);
    end
    lows = 0;
    repeat (40) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL rst tx_quiet: low_cycles=%0d required=0", lows); end
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = 3'd0;
    bus.i_cmd_addr  = 32'd0;
    bus.i_cmd_data  = 32'd0;
    test_reset();
    test_read();
    test_write();
    test_reset_run();
    test_back_to_back();
    test_errors();
    test_illegal_and_rst();
    checks++;
    if (long_pulses != 0) begin
      errors++; $display("FAIL rsp_pulse_width: multi_cycle_pulses=%0d required=0", long_pulses);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
